// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types for the instruction fetch stage.
// FSM state enum, queue entry struct and word-size constant.
package ifetch_pkg;

  localparam int IF_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO, parameterised data type and depth.
// Ports: clk, rst_n, clr_i, push_i/data_i, pop_i/data_o, count_o, full_o, empty_o.
module ifetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage with credit-limited requests, in-order
// prefetch queue and redirect drain. Ports: pc/flush/pc_adv to the PC
// register, imem_* request/grant/response, instr_* valid/ready to decode,
// fetch_misalign. Macro IFETCH_ALIGN_CHECK_EN enables the misalign check.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_adv,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_misalign
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(IF_WORD_BYTES);

  ifetch_state_e state_q;
  logic [CW-1:0] drop_q;
  logic          mis_q;

  logic [CW-1:0] q_count;
  logic [CW-1:0] pcf_count;
  logic [CW:0]   used;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_nx;
  logic          iq_empty;
  logic          iq_full;
  logic          pcf_empty;
  logic          pcf_full;
  logic          credit;
  logic          req_blk;
  logic          pc_misal;
  logic          grant;
  logic          keep;
  logic          pop;
  logic [31:0]   rsp_pc;
  ifetch_entry_t push_ent;
  ifetch_entry_t head;
  logic          unused;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign pc_misal = |pc[OW-1:0];
  assign req_blk  = pc_misal | mis_q;
  assign unused   = &{1'b0, iq_full, pcf_full};
`else
  assign pc_misal = 1'b0;
  assign req_blk  = 1'b0;
  assign unused   = &{1'b0, iq_full, pcf_full, pc[OW-1:0]};
`endif

  // The PC FIFO count doubles as the outstanding-request counter.
  assign used     = {1'b0, q_count} + {1'b0, pcf_count};
  assign credit   = (used < (CW+1)'(DEPTH));
  assign imem_req = (state_q == FETCH) && !flush && credit && !req_blk;
  assign imem_addr = imem_req ? {pc[31:OW], OW'(0)} : '0;
  assign grant    = imem_req && imem_gnt;
  assign pc_adv   = grant;

  assign keep = imem_rvalid && !flush
             && (state_q == FETCH) && !pcf_empty;
  assign pop  = instr_valid && instr_ready && !flush;

  // In-flight responses still to arrive; one of the terms is always 0.
  assign inflight = pcf_count + drop_q;
  assign drop_nx  = inflight
                  - CW'(imem_rvalid && (inflight != '0));

  assign push_ent.pc    = rsp_pc;
  assign push_ent.instr = imem_rdata;

  assign instr_valid    = !iq_empty;
  assign instr          = head.instr;
  assign instr_pc       = head.pc;
  assign fetch_misalign = mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drop_q  <= '0;
      mis_q   <= 1'b0;
    end else if (flush) begin
      drop_q  <= drop_nx;
      mis_q   <= 1'b0;
      state_q <= (drop_nx != '0) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: mis_q <= mis_q | pc_misal;
        DRAIN: begin
          if (drop_q == '0) begin
            state_q <= FETCH;
          end else if (imem_rvalid) begin
            drop_q <= drop_q - CW'(1);
            if (drop_q == CW'(1)) begin
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ifetch_fifo #(
    .T     (logic [31:0]),
    .DEPTH (DEPTH)
  ) u_pcf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (grant),
    .data_i  (pc),
    .pop_i   (keep),
    .data_o  (rsp_pc),
    .count_o (pcf_count),
    .full_o  (pcf_full),
    .empty_o (pcf_empty)
  );

  ifetch_fifo #(
    .T     (ifetch_entry_t),
    .DEPTH (DEPTH)
  ) u_iq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (keep),
    .data_i  (push_ent),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (q_count),
    .full_o  (iq_full),
    .empty_o (iq_empty)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue with a memory/PC model
// and an in-order scoreboard of expected {pc, instr} entries.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        pc_adv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        fetch_misalign;

  int n_chk = 0;
  int n_err = 0;
  int lat = 1;
  int cyc = 0;
  int n_gnt = 0;
  int n_acc = 0;
  logic [31:0] redir = '0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t         pend[$];
  ifetch_entry_t exp_q[$];

  ifetch_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .flush          (flush),
    .pc_adv         (pc_adv),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] t);
    @(posedge clk); #2;
    flush = 1'b1;
    redir = t;
    @(posedge clk); #2;
    flush = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] epc);
    int k;
    k = 0;
    while (!instr_valid && k < 30) begin
      ncyc(1);
      k++;
    end
    chk1({tag, "_v"}, instr_valid, 1'b1);
    chk(tag, instr_pc, epc);
  endtask

  // Memory, PC register and scoreboard.
  initial begin : env
    logic          g;
    logic          fl;
    logic          adv;
    logic [31:0]   ga;
    logic [31:0]   gp;
    ifetch_entry_t e;
    forever begin
      @(negedge clk);
      g  = 1'b0;
      fl = 1'b0;
      if (!rst_n) begin
        pend.delete();
        exp_q.delete();
      end else begin
        if (instr_valid && instr_ready && !flush) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            chk("sb_extra", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc, e.pc);
            chk("sb_instr", instr, e.instr);
          end
        end
        if (imem_req) chk("addr", imem_addr, {pc[31:2], 2'b00});
        g  = imem_req && imem_gnt;
        fl = flush;
        ga = imem_addr;
        gp = pc;
        if (fl) exp_q.delete();
        if (g) begin
          n_gnt++;
          exp_q.push_back('{pc: gp, instr: word(ga)});
          pend.push_back('{a: ga, due: cyc + lat});
        end
      end
      adv = pc_adv;
      @(posedge clk); #1;
      cyc++;
      if (fl) pc = redir;
      else if (adv) pc = pc + 32'd4;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend[0].a);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin : main
    int          snap;
    int          k;
    logic [31:0] held;

    // Reset values.
    ncyc(3);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_adv", pc_adv, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk1("rst_mis", fetch_misalign, 1'b0);
    rst_n = 1'b1;

    // Streaming from pc 0 with single-cycle memory.
    ncyc(1);
    chk1("t1_req0", imem_req, 1'b1);
    chk("t1_a0", imem_addr, 32'h0);
    chk1("t1_adv0", pc_adv, 1'b1);
    chk1("t1_v0", instr_valid, 1'b0);
    ncyc(1);
    chk("t1_a1", imem_addr, 32'h4);
    chk1("t1_v1", instr_valid, 1'b0);
    ncyc(1);
    chk("t1_a2", imem_addr, 32'h8);
    chk1("t1_v2", instr_valid, 1'b1);
    chk("t1_ipc0", instr_pc, 32'h0);
    chk("t1_ins0", instr, word(32'h0));
    ncyc(1);
    chk("t1_ipc1", instr_pc, 32'h4);
    snap = n_acc;
    ncyc(8);
    chk("t1_thru", 32'(n_acc - snap), 32'd8);

    // Back-pressure: exactly DEPTH grants, then one per pop.
    @(posedge clk); #2;
    instr_ready = 1'b0;
    do_flush(32'h400);
    snap = n_gnt;
    ncyc(10);
    chk("t2_grants", 32'(n_gnt - snap), 32'd4);
    chk1("t2_req", imem_req, 1'b0);
    chk1("t2_adv", pc_adv, 1'b0);
    chk("t2_head", instr_pc, 32'h400);
    @(posedge clk); #2;
    instr_ready = 1'b1;
    @(posedge clk); #2;
    instr_ready = 1'b0;
    snap = n_gnt;
    ncyc(6);
    chk("t2_refill", 32'(n_gnt - snap), 32'd1);
    chk1("t2_req2", imem_req, 1'b0);

    // Flush with two stale fetches in flight, latency 3.
    @(posedge clk); #2;
    instr_ready = 1'b1;
    imem_gnt = 1'b0;
    lat = 3;
    ncyc(10);
    @(posedge clk); #2;
    imem_gnt = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    flush = 1'b1;
    redir = 32'h100;
    ncyc(1);
    chk1("t3_req_fl", imem_req, 1'b0);
    @(posedge clk); #2;
    flush = 1'b0;
    ncyc(1);
    chk1("t3_v_after", instr_valid, 1'b0);
    k = 0;
    while (!imem_req && k < 20) begin
      ncyc(1);
      k++;
    end
    chk1("t3_req", imem_req, 1'b1);
    chk("t3_addr", imem_addr, 32'h100);
    chk1("t3_drain_len", k >= 1, 1'b1);
    wait_valid("t3_ipc", 32'h100);

    // Flush coinciding with the only response in flight.
    @(posedge clk); #2;
    imem_gnt = 1'b0;
    ncyc(10);
    @(posedge clk); #2;
    imem_gnt = 1'b1;
    @(posedge clk); #2;
    imem_gnt = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    flush = 1'b1;
    redir = 32'h300;
    imem_gnt = 1'b1;
    ncyc(1);
    chk1("t4_req_fl", imem_req, 1'b0);
    @(posedge clk); #2;
    flush = 1'b0;
    ncyc(1);
    chk1("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 32'h300);
    chk1("t4_adv", pc_adv, 1'b1);
    wait_valid("t4_ipc", 32'h300);

    // Grant stall: request and address held, no PC advance.
    @(posedge clk); #2;
    imem_gnt = 1'b0;
    ncyc(10);
    lat = 1;
    @(posedge clk); #2;
    imem_gnt = 1'b1;
    ncyc(6);
    @(posedge clk); #2;
    imem_gnt = 1'b0;
    ncyc(1);
    held = imem_addr;
    for (int i = 0; i < 5; i++) begin
      chk1("t5_req", imem_req, 1'b1);
      chk("t5_addr", imem_addr, held);
      chk1("t5_adv", pc_adv, 1'b0);
      if (i < 4) ncyc(1);
    end
    @(posedge clk); #2;
    imem_gnt = 1'b1;
    ncyc(1);
    chk1("t5_adv_go", pc_adv, 1'b1);
    chk("t5_addr_go", imem_addr, held);

    // Misaligned PC.
    ncyc(4);
    do_flush(32'h102);
`ifdef IFETCH_ALIGN_CHECK_EN
    ncyc(1);
    chk1("t6_req0", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ncyc(1);
      chk1("t6_req", imem_req, 1'b0);
      chk1("t6_mis", fetch_misalign, 1'b1);
    end
`else
    ncyc(1);
    chk1("t6_req", imem_req, 1'b1);
    chk("t6_addr", imem_addr, 32'h100);
    chk1("t6_mis", fetch_misalign, 1'b0);
    ncyc(3);
`endif
    do_flush(32'h200);
    ncyc(1);
    chk1("t6_mis_clr", fetch_misalign, 1'b0);
    chk1("t6_req2", imem_req, 1'b1);
    chk("t6_addr2", imem_addr, 32'h200);
    wait_valid("t6_ipc", 32'h200);
    ncyc(10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
